regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback sources: the ALU (single-cycle) and the LSU (multi-cycle loads).
- Keeps a per-register busy scoreboard for outstanding loads and flags read-after-write hazards to the decode/stall logic.
- Sits between the execute/memory stages and the register-file write port (regw_en / rd_addr / rd_data). Only one write is presented per cycle.

---
 rtl/regfile_wb_arbiter.sv | 123 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: round-robin share of the single write port
// between ALU and LSU, with a busy scoreboard for outstanding loads and RAW hazard flag.
module regfile_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid_i,
  input  logic [ADDR_W-1:0] alu_rd_i,
  input  logic [DATA_W-1:0] alu_data_i,
  output logic              alu_ready_o,
  input  logic              lsu_valid_i,
  input  logic [ADDR_W-1:0] lsu_rd_i,
  input  logic [DATA_W-1:0] lsu_data_i,
  output logic              lsu_ready_o,
  input  logic              iss_load_i,
  input  logic [ADDR_W-1:0] iss_rd_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic              hazard_o,
  output logic              regw_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [NREG-1:0]   busy_o,
  output logic              err_o
);

  typedef enum logic {PTR_ALU, PTR_LSU} ptr_e;

  ptr_e              ptr_q, ptr_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              err_q, err_d;
  logic              regw_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] rd_data_q;

  logic alu_elig, lsu_elig, alu_gnt, lsu_gnt;
  logic lsu_clr, iss_set, iss_clr_same;

  // ALU waits behind a pending load to the same register (WAW ordering).
  assign alu_elig = alu_valid_i && !((alu_rd_i != '0) && busy_q[alu_rd_i]);
  assign lsu_elig = lsu_valid_i;

  // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    alu_gnt = 1'b0;
    lsu_gnt = 1'b0;
    ptr_d   = ptr_q;
    if (alu_elig && lsu_elig) begin
      if (ptr_q == PTR_ALU) begin
        alu_gnt = 1'b1;
        ptr_d   = PTR_LSU;
      end else begin
        lsu_gnt = 1'b1;
        ptr_d   = PTR_ALU;
      end
    end else begin
      alu_gnt = alu_elig;
      lsu_gnt = lsu_elig;
    end
  end

  // No downstream backpressure: ready is simply the grant, held low in reset.
  assign alu_ready_o = alu_gnt && rst_n;
  assign lsu_ready_o = lsu_gnt && rst_n;

  assign lsu_clr      = lsu_gnt && (lsu_rd_i != '0);
  assign iss_set      = iss_load_i && (iss_rd_i != '0);
  assign iss_clr_same = lsu_clr && (lsu_rd_i == iss_rd_i);

  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    if (lsu_clr) busy_d[lsu_rd_i] = 1'b0;
    if (iss_set) begin
      if (busy_q[iss_rd_i] && !iss_clr_same) err_d = 1'b1;
      busy_d[iss_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= PTR_ALU;
      busy_q    <= '0;
      err_q     <= 1'b0;
      regw_en_q <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      busy_q <= busy_d;
      err_q  <= err_d;
      if (alu_gnt) begin
        regw_en_q <= (alu_rd_i != '0);
        rd_addr_q <= alu_rd_i;
        rd_data_q <= alu_data_i;
      end else if (lsu_gnt) begin
        regw_en_q <= (lsu_rd_i != '0);
        rd_addr_q <= lsu_rd_i;
        rd_data_q <= lsu_data_i;
      end else begin
        regw_en_q <= 1'b0;
      end
    end
  end

  // A staged write counts as not-yet-visible, just like a pending load.
  function automatic logic src_hazard(input logic [ADDR_W-1:0] rs);
    return (rs != '0) && (busy_q[rs] || (regw_en_q && (rd_addr_q == rs)));
  endfunction

  assign hazard_o  = src_hazard(rs1_addr_i) || src_hazard(rs2_addr_i);
  assign regw_en_o = regw_en_q;
  assign rd_addr_o = rd_addr_q;
  assign rd_data_o = rd_data_q;
  assign busy_o    = busy_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter: inputs change on the
// falling edge, outputs are sampled 1ns later, well clear of the rising edge.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid_i = 1'b0;
  logic [2:0]  alu_rd_i = '0;
  logic [15:0] alu_data_i = '0;
  logic        alu_ready_o;
  logic        lsu_valid_i = 1'b0;
  logic [2:0]  lsu_rd_i = '0;
  logic [15:0] lsu_data_i = '0;
  logic        lsu_ready_o;
  logic        iss_load_i = 1'b0;
  logic [2:0]  iss_rd_i = '0;
  logic [2:0]  rs1_addr_i = '0;
  logic [2:0]  rs2_addr_i = '0;
  logic        hazard_o;
  logic        regw_en_o;
  logic [2:0]  rd_addr_o;
  logic [15:0] rd_data_o;
  logic [7:0]  busy_o;
  logic        err_o;

  int checks = 0;
  int failures = 0;

  regfile_wb_arbiter #(.DATA_W(16), .ADDR_W(3), .NREG(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i), .alu_ready_o(alu_ready_o),
    .lsu_valid_i(lsu_valid_i), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i), .lsu_ready_o(lsu_ready_o),
    .iss_load_i(iss_load_i), .iss_rd_i(iss_rd_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .hazard_o(hazard_o),
    .regw_en_o(regw_en_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_valid_i = 1'b0;
    lsu_valid_i = 1'b0;
    iss_load_i  = 1'b0;
  endtask

  // Advance to the next falling edge (one rising edge in between).
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_regw_en", 32'(regw_en_o), 32'd0);
    check("rst_rd_addr", 32'(rd_addr_o), 32'd0);
    check("rst_rd_data", 32'(rd_data_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_alu_ready", 32'(alu_ready_o), 32'd0);
    check("rst_lsu_ready", 32'(lsu_ready_o), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Single ALU write
    alu_valid_i = 1'b1; alu_rd_i = 3'd3; alu_data_i = 16'h1234;
    settle();
    check("alu1_ready", 32'(alu_ready_o), 32'd1);
    check("alu1_lsu_ready", 32'(lsu_ready_o), 32'd0);
    step();
    idle_inputs(); rs1_addr_i = 3'd3;
    settle();
    check("alu1_regw_en", 32'(regw_en_o), 32'd1);
    check("alu1_rd_addr", 32'(rd_addr_o), 32'd3);
    check("alu1_rd_data", 32'(rd_data_o), 32'h1234);
    check("alu1_hazard_staged", 32'(hazard_o), 32'd1);
    step();
    settle();
    check("alu1_regw_en_off", 32'(regw_en_o), 32'd0);
    check("alu1_hazard_gone", 32'(hazard_o), 32'd0);
    check("alu1_addr_hold", 32'(rd_addr_o), 32'd3);
    rs1_addr_i = 3'd0;

    // Contention: pointer at ALU -> ALU, LSU, ALU, LSU
    for (int i = 0; i < 4; i++) begin
      step();
      alu_valid_i = 1'b1; alu_rd_i = 3'd1; alu_data_i = 16'h1111;
      lsu_valid_i = 1'b1; lsu_rd_i = 3'd2; lsu_data_i = 16'h2222;
      settle();
      check($sformatf("rr%0d_alu_ready", i), 32'(alu_ready_o), 32'((i % 2) == 0));
      check($sformatf("rr%0d_lsu_ready", i), 32'(lsu_ready_o), 32'((i % 2) == 1));
      if (i > 0) begin
        check($sformatf("rr%0d_regw_en", i), 32'(regw_en_o), 32'd1);
        check($sformatf("rr%0d_rd_addr", i), 32'(rd_addr_o), ((i - 1) % 2 == 0) ? 32'd1 : 32'd2);
      end
    end
    step();
    idle_inputs();
    settle();
    check("rr_last_regw_en", 32'(regw_en_o), 32'd1);
    check("rr_last_rd_data", 32'(rd_data_o), 32'h2222);
    step();
    settle();
    check("rr_done_regw_en", 32'(regw_en_o), 32'd0);

    // Load scoreboard and WAW stall
    step();
    iss_load_i = 1'b1; iss_rd_i = 3'd5;
    step();
    idle_inputs(); rs2_addr_i = 3'd5;
    alu_valid_i = 1'b1; alu_rd_i = 3'd5; alu_data_i = 16'h5555;
    settle();
    check("ld_busy", 32'(busy_o), 32'h20);
    check("ld_hazard", 32'(hazard_o), 32'd1);
    check("ld_alu_stall", 32'(alu_ready_o), 32'd0);
    step();
    lsu_valid_i = 1'b1; lsu_rd_i = 3'd5; lsu_data_i = 16'hBEEF;
    settle();
    check("ld_alu_stall2", 32'(alu_ready_o), 32'd0);
    check("ld_lsu_ready", 32'(lsu_ready_o), 32'd1);
    step();
    lsu_valid_i = 1'b0;
    settle();
    check("ld_busy_clr", 32'(busy_o), 32'd0);
    check("ld_wb_en", 32'(regw_en_o), 32'd1);
    check("ld_wb_addr", 32'(rd_addr_o), 32'd5);
    check("ld_wb_data", 32'(rd_data_o), 32'hBEEF);
    check("ld_alu_accept", 32'(alu_ready_o), 32'd1);
    check("ld_hazard_staged", 32'(hazard_o), 32'd1);
    step();
    idle_inputs(); rs2_addr_i = 3'd0;
    settle();
    check("ld_alu_wb_data", 32'(rd_data_o), 32'h5555);

    // x0 handling
    step();
    alu_valid_i = 1'b1; alu_rd_i = 3'd0; alu_data_i = 16'hAAAA;
    iss_load_i = 1'b1; iss_rd_i = 3'd0;
    settle();
    check("x0_alu_ready", 32'(alu_ready_o), 32'd1);
    check("x0_hazard", 32'(hazard_o), 32'd0);
    step();
    idle_inputs();
    settle();
    check("x0_regw_en", 32'(regw_en_o), 32'd0);
    check("x0_busy", 32'(busy_o), 32'd0);

    // Double issue raises sticky err
    step();
    iss_load_i = 1'b1; iss_rd_i = 3'd4;
    step();
    settle();
    check("dbl_err_not_yet", 32'(err_o), 32'd0);
    step();
    idle_inputs();
    settle();
    check("dbl_err", 32'(err_o), 32'd1);
    check("dbl_busy", 32'(busy_o), 32'h10);
    step();
    settle();
    check("dbl_err_sticky", 32'(err_o), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    settle();
    check("dbl_err_reset", 32'(err_o), 32'd0);

    // Same-cycle clear and re-issue: set wins, no error
    step();
    iss_load_i = 1'b1; iss_rd_i = 3'd4;
    step();
    lsu_valid_i = 1'b1; lsu_rd_i = 3'd4; lsu_data_i = 16'h0044;
    settle();
    check("b2b_lsu_ready", 32'(lsu_ready_o), 32'd1);
    step();
    idle_inputs();
    settle();
    check("b2b_busy", 32'(busy_o), 32'h10);
    check("b2b_err", 32'(err_o), 32'd0);
    lsu_valid_i = 1'b1; lsu_rd_i = 3'd4;
    step();
    idle_inputs();
    settle();
    check("b2b_busy_clr", 32'(busy_o), 32'd0);

    // Async reset mid-cycle with staged write and busy=0x06
    step();
    iss_load_i = 1'b1; iss_rd_i = 3'd1;
    step();
    iss_rd_i = 3'd2;
    step();
    iss_load_i = 1'b0;
    alu_valid_i = 1'b1; alu_rd_i = 3'd3; alu_data_i = 16'h3333;
    step();
    idle_inputs(); rs1_addr_i = 3'd1;
    settle();
    check("ar_pre_regw_en", 32'(regw_en_o), 32'd1);
    check("ar_pre_busy", 32'(busy_o), 32'h06);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_regw_en", 32'(regw_en_o), 32'd0);
    check("ar_rd_addr", 32'(rd_addr_o), 32'd0);
    check("ar_rd_data", 32'(rd_data_o), 32'd0);
    check("ar_busy", 32'(busy_o), 32'd0);
    check("ar_err", 32'(err_o), 32'd0);
    check("ar_hazard", 32'(hazard_o), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    settle();
    check("ar_post_busy", 32'(busy_o), 32'd0);
    check("ar_post_regw_en", 32'(regw_en_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
